// File: rtl/turing_sub.sv
// turing_sub: unary subtractor Turing machine. It computes A-B in place on a
// tape laid out as 0, A ones, gap zeros, B ones, trailing zeros.
// Optional feature: define TURING_SUB_STEPS_EN to count busy cycles on steps.
module turing_sub #(
    parameter int unsigned TAPE_W = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [TAPE_W-1:0]           din,
    output logic [TAPE_W-1:0]           dout,
    output logic [$clog2(TAPE_W)-1:0]   head,
    output logic                        busy,
    output logic                        done,
    output logic                        underflow,
    output logic [7:0]                  steps
);

    localparam int unsigned HEAD_W = $clog2(TAPE_W);
    localparam logic [HEAD_W-1:0] LAST  = HEAD_W'(TAPE_W - 1);
    localparam logic [HEAD_W-1:0] FIRST = HEAD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_A, S_FIND_B, S_ERASE_B,
        S_ERASE_A, S_REWIND, S_UNDERFLOW, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TAPE_W-1:0]   tape_q, tape_d;
    logic [HEAD_W-1:0]   head_q, head_d;
    logic [HEAD_W-1:0]   mark_q, mark_d;
    logic                aempty_q, aempty_d;
    logic                underflow_q, underflow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_acc;
    logic                cur_bit;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cur_bit   = tape_q[head_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_acc) state_d = S_SCAN_A;
            S_SCAN_A: begin
                // A reaching the last cell, or a gap at the last cell, leaves no room for B
                if (head_q == LAST)  state_d = S_DONE;
                else if (!cur_bit)   state_d = S_FIND_B;
            end
            S_FIND_B: begin
                if (cur_bit)             state_d = aempty_q ? S_UNDERFLOW : S_ERASE_B;
                else if (head_q == LAST) state_d = S_DONE;
            end
            S_ERASE_B:   state_d = S_ERASE_A;
            S_ERASE_A:   state_d = S_REWIND;
            S_REWIND:    if (head_q <= FIRST) state_d = S_SCAN_A;
            S_UNDERFLOW: state_d = S_DONE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath next values (tape, head, mark, flags)
    always_comb begin
        tape_d      = tape_q;
        head_d      = head_q;
        mark_d      = mark_q;
        aempty_d    = aempty_q;
        underflow_d = underflow_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    tape_d      = {din[TAPE_W-1:1], 1'b0};
                    head_d      = FIRST;
                    underflow_d = 1'b0;
                end
            end
            S_SCAN_A: begin
                if (cur_bit) mark_d   = head_q;
                else         aempty_d = (head_q == FIRST);
                if (head_q != LAST) head_d = head_q + HEAD_W'(1);
            end
            S_FIND_B: begin
                if (!cur_bit && head_q != LAST) head_d = head_q + HEAD_W'(1);
            end
            S_ERASE_B:   tape_d[head_q] = 1'b0;
            S_ERASE_A:   tape_d[mark_q] = 1'b0;
            S_REWIND:    if (head_q > FIRST) head_d = head_q - HEAD_W'(1);
            S_UNDERFLOW: underflow_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tape_q      <= '0;
            head_q      <= '0;
            mark_q      <= '0;
            aempty_q    <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tape_q      <= tape_d;
            head_q      <= head_d;
            mark_q      <= mark_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef TURING_SUB_STEPS_EN
    logic [7:0] steps_q;

    // Saturating busy-cycle counter, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         steps_q <= '0;
        else if (start_acc)                 steps_q <= '0;
        else if (busy_q && steps_q != 8'hFF) steps_q <= steps_q + 8'd1;
    end

    assign steps = steps_q;
`else
    assign steps = '0;
`endif

    assign dout      = tape_q;
    assign head      = head_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_turing_sub.sv
// Directed bench for turing_sub with hand-computed tape results.
module tb_turing_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] din;
    logic [9:0] dout;
    logic [3:0] head;
    logic       busy;
    logic       done;
    logic       underflow;
    logic [7:0] steps;

    int tests = 0;
    int fails = 0;
    logic [7:0] steps_a;

    turing_sub #(.TAPE_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .dout      (dout),
        .head      (head),
        .busy      (busy),
        .done      (done),
        .underflow (underflow),
        .steps     (steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [9:0] d);
        @(negedge clk);
        din   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic run(input string tag, input logic [9:0] d,
                       input logic [9:0] exp_dout, input logic exp_uf);
        pulse_start(d);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        wait_done();
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        check({tag, "_underflow"}, 32'(underflow), 32'(exp_uf));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_head", 32'(head), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);
        check("rst_steps", 32'(steps), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A=4, B=2 -> A-B=2
        run("a4b2", 10'b00_11_0_1111_0, 10'b00_0000_0110, 1'b0);
        check("a4b2_head", 32'(head), 32'd9);
        steps_a = steps;
        // done and tape held while idle in DONE
        repeat (5) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_dout", 32'(dout), 32'h006);

        // repeat run for step-count repeatability
        run("a4b2_rep", 10'b00_11_0_1111_0, 10'b00_0000_0110, 1'b0);
`ifdef TURING_SUB_STEPS_EN
        check("steps_nonzero", 32'(steps != 8'd0), 32'd1);
        check("steps_repeat", 32'(steps), 32'(steps_a));
`else
        check("steps_zero", 32'(steps), 32'd0);
`endif

        // A=2, B=4 -> underflow, tape keeps remaining two B cells
        run("a2b4", 10'b00_1111_0_11_0, 10'b00_1100_0000, 1'b1);
        check("a2b4_head", 32'(head), 32'd6);

        // B empty: tape unchanged; underflow cleared from previous run
        run("bempty", 10'b00_0001_1110, 10'b00_0001_1110, 1'b0);
        // empty tape
        run("zero", 10'b0, 10'b0, 1'b0);
        // cell 0 is forced to 0 on load
        run("cell0", 10'b00_0000_0111, 10'b00_0000_0110, 1'b0);
        // A fills every cell up to the last one
        run("afull", 10'b11_1111_1110, 10'b11_1111_1110, 1'b0);
        check("afull_head", 32'(head), 32'd9);

        // A=3, B=2 with a wide gap; a start while busy is ignored
        pulse_start(10'b00_11_0_0_111_0);
        repeat (3) @(negedge clk);
        check("ign_busy", 32'(busy), 32'd1);
        pulse_start(10'b11_1111_1110);
        wait_done();
        check("ign_dout", 32'(dout), 32'h002);
        check("ign_uf", 32'(underflow), 32'd0);

        // Reset mid-run abandons the run
        pulse_start(10'b00_11_0_1111_0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_head", 32'(head), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_steps", 32'(steps), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run("after_rst", 10'b00_11_0_1111_0, 10'b00_0000_0110, 1'b0);
`ifdef TURING_SUB_STEPS_EN
        check("after_rst_steps", 32'(steps), 32'(steps_a));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/turing_sub.md
TURING_SUB -- requirements
Module: turing_sub

Interface
REQ-001 SHALL have parameter TAPE_W, default 10, meaning tape length in cells (the Function section uses 10).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: load din and begin a run.
REQ-005 SHALL have port din, input, 10 bits: initial tape, cell i = din[i].
REQ-006 SHALL have port dout, output, 10 bits: current tape contents.
REQ-007 SHALL have port head, output, 4 bits: current head index.
REQ-008 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: run finished; held until the next start.
REQ-010 SHALL have port underflow, output, 1 bit: B > A detected; valid while done.
REQ-011 SHALL have port steps, output, 8 bits: cycle count of the last run (see Configuration).

Function
REQ-012 Tape format SHALL be: cell 0 blank; A = run of 1s from cell 1; a separator of one or more 0s; B = run of 1s; trailing 0s. The block computes unary A-B in place (subtractor counterpart of the unary adder).
REQ-013 start SHALL be accepted only in IDLE or DONE: tape<=din with cell 0 forced to 0, head<=1, done<=0, underflow<=0, busy<=1, next state SCAN_A.
REQ-014 start while busy SHALL be ignored.
REQ-015 SCAN_A SHALL, each cycle: if tape[head]==1, set mark<=head and, if head==9, go to DONE (B empty); otherwise head<=head+1.
REQ-016 SCAN_A SHALL, when tape[head]==0, set aempty<=(head==1) and go to FIND_B with head<=head+1.
REQ-017 FIND_B SHALL, each cycle: if tape[head]==1, go to UNDERFLOW when aempty==1, else go to ERASE_B.
REQ-018 FIND_B SHALL, when tape[head]==0: go to DONE if head==9, else head<=head+1.
REQ-019 ERASE_B SHALL write tape[head]<=0 in one cycle, then go to ERASE_A.
REQ-020 ERASE_A SHALL write tape[mark]<=0 in one cycle, then go to REWIND.
REQ-021 REWIND SHALL do head<=head-1 each cycle until head==1, then go to SCAN_A.
REQ-022 UNDERFLOW SHALL, in one cycle, set underflow<=1 with the tape unchanged, then go to DONE.
REQ-023 DONE SHALL hold busy=0 and done=1; tape and head SHALL hold their values.
REQ-024 Head movement SHALL be at most one cell per cycle; head SHALL never exceed 9 nor go below 0.
REQ-025 dout SHALL always reflect the registered tape, with no combinational path from din.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, tape=0, head=0, mark=0, aempty=0, busy=0, done=0, underflow=0, steps=0.
REQ-027 Reset asserted mid-run SHALL abandon the run; no done pulse SHALL follow release.
REQ-028 The first accepted start SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 With macro TURING_SUB_STEPS_EN defined, steps SHALL clear on start, increment by 1 every busy cycle, saturate at 255, and hold in DONE.
REQ-030 Without TURING_SUB_STEPS_EN, steps SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-031 din=10'b00_11_0_1111_0 (A=4, B=2), start -> done=1, underflow=0, dout=10'b00_0000_0110.
REQ-032 din=10'b00_1111_0_11_0 (A=2, B=4), start -> done=1, underflow=1, dout=10'b00_1100_0000.
REQ-033 din=10'b00_0001_1110 (B empty) -> done=1, underflow=0, dout=10'b00_0001_1110. din=0 -> done=1, dout=0, underflow=0.
REQ-034 din=10'b00_11_0_0_111_0 (A=3, B=2, wide gap), start; pulse start again while busy with a different din -> second start ignored, final dout=10'b00_0000_0010.
REQ-035 Drive rst_n low for one cycle mid-run of the REQ-031 stimulus -> all outputs 0 immediately; a later start with the same din reproduces the REQ-031 result.
REQ-036 With TURING_SUB_STEPS_EN defined, steps on done SHALL be nonzero and identical across repeated runs with the same din; with the macro undefined, steps SHALL be 0.
